// File: rtl/duck_gfx_pkg.sv
// Shared types and constants for the duck graphics pipeline: palette index,
// 12-bit RGB colour and the palette scheduler state encoding.
package duck_gfx_pkg;

  typedef logic [3:0] pal_index_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  localparam pal_index_t PAL_BG    = 4'd0;
  localparam pal_index_t PAL_WHITE = 4'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_LOOKUP,
    ST_WAIT
  } sched_state_t;

endpackage

// File: rtl/duck_flash_timer.sv
// Hit-flash pixel counter: a trigger loads FLASH_PIXELS, each finished pixel
// counts down to zero. Only used when DUCK_FLASH_EN is defined.
module duck_flash_timer #(
  parameter logic [15:0] FLASH_PIXELS = 16'd4096
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_trig,
  input  logic i_dec,
  output logic o_active
);

  logic [15:0] r_count;

  // A trigger beats a simultaneous decrement so a retrigger always restarts the flash.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_trig) begin
      r_count <= FLASH_PIXELS;
    end else if (i_dec && (r_count != 16'd0)) begin
      r_count <= r_count - 16'd1;
    end
  end

  assign o_active = (r_count != 16'd0);

endmodule

// File: rtl/duck_palette_sched.sv
// Per-pixel scheduler sharing one synchronous palette ROM among sprite layers.
// Optional hit-flash white remap is enabled with the DUCK_FLASH_EN macro.
module duck_palette_sched
  import duck_gfx_pkg::*;
#(
  parameter int NUM_LAYERS = 4
`ifdef DUCK_FLASH_EN
  , parameter logic [15:0] FLASH_PIXELS = 16'd4096
`endif
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
`ifdef DUCK_FLASH_EN
  input  logic                    i_flash_trig,
`endif
  input  logic                    i_pix_req,
  input  logic [NUM_LAYERS-1:0]   i_layer_valid,
  input  logic [4*NUM_LAYERS-1:0] i_layer_index,
  output logic [3:0]              o_pal_index,
  input  logic [3:0]              i_pal_red,
  input  logic [3:0]              i_pal_green,
  input  logic [3:0]              i_pal_blue,
  output logic [3:0]              o_red,
  output logic [3:0]              o_green,
  output logic [3:0]              o_blue,
  output logic                    o_rgb_valid,
  output logic                    o_busy
);

  localparam int PTR_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_LAYERS - 1);

  sched_state_t            r_state;
  sched_state_t            w_next;
  logic [PTR_W-1:0]        r_ptr;
  logic [NUM_LAYERS-1:0]   r_valid;
  logic [4*NUM_LAYERS-1:0] r_index;
  pal_index_t              r_pal_index;
  rgb444_t                 r_rgb;
  logic                    r_rgb_valid;

  pal_index_t w_cur_index;
  pal_index_t w_load_index;
  logic       w_hit;
  logic       w_accept;
  logic       w_load;
  logic       w_done;
  logic       w_flash_active;

  assign w_cur_index = r_index[4*r_ptr +: 4];
  assign w_hit       = r_valid[r_ptr] && (w_cur_index != PAL_BG);

`ifdef DUCK_FLASH_EN
  duck_flash_timer #(
    .FLASH_PIXELS(FLASH_PIXELS)
  ) u_flash (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_trig   (i_flash_trig),
    .i_dec    (w_done),
    .o_active (w_flash_active)
  );
`else
  assign w_flash_active = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Background never gets the flash remap; only real hits turn white.
  always_comb begin
    w_next       = r_state;
    w_accept     = 1'b0;
    w_load       = 1'b0;
    w_load_index = PAL_BG;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_pix_req) begin
          w_accept = 1'b1;
          w_next   = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (w_hit) begin
          w_load       = 1'b1;
          w_load_index = w_flash_active ? PAL_WHITE : w_cur_index;
          w_next       = ST_LOOKUP;
        end else if (r_ptr == LAST_PTR) begin
          w_load = 1'b1;
          w_next = ST_LOOKUP;
        end
      end
      ST_LOOKUP: w_next = ST_WAIT;
      ST_WAIT: begin
        w_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr       <= '0;
      r_valid     <= '0;
      r_index     <= '0;
      r_pal_index <= PAL_BG;
      r_rgb       <= '0;
      r_rgb_valid <= 1'b0;
    end else begin
      r_rgb_valid <= w_done;
      if (w_accept) begin
        r_valid <= i_layer_valid;
        r_index <= i_layer_index;
        r_ptr   <= '0;
      end else if ((r_state == ST_SCAN) && !w_load) begin
        r_ptr <= r_ptr + PTR_W'(1);
      end
      if (w_load) begin
        r_pal_index <= w_load_index;
      end
      if (w_done) begin
        r_rgb <= {i_pal_red, i_pal_green, i_pal_blue};
      end
    end
  end

  assign o_pal_index = r_pal_index;
  assign o_red       = r_rgb.r;
  assign o_green     = r_rgb.g;
  assign o_blue      = r_rgb.b;
  assign o_rgb_valid = r_rgb_valid;
  assign o_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_duck_palette_sched.sv
// Self-checking bench for duck_palette_sched with a behavioural palette ROM,
// directed vector table, corner-case sequences and randomized pixels.
`timescale 1ns/1ps
module tb_duck_palette_sched;

  localparam int NL = 4;
`ifdef DUCK_FLASH_EN
  localparam logic [15:0] FP = 16'd2;
`endif

  logic            i_clk = 1'b0;
  logic            i_rst_n = 1'b1;
  logic            i_pix_req = 1'b0;
  logic [NL-1:0]   i_layer_valid = '0;
  logic [4*NL-1:0] i_layer_index = '0;
  logic [3:0]      o_pal_index;
  logic [3:0]      i_pal_red = '0;
  logic [3:0]      i_pal_green = '0;
  logic [3:0]      i_pal_blue = '0;
  logic [3:0]      o_red;
  logic [3:0]      o_green;
  logic [3:0]      o_blue;
  logic            o_rgb_valid;
  logic            o_busy;
`ifdef DUCK_FLASH_EN
  logic            i_flash_trig = 1'b0;
`endif

  always #5 i_clk = ~i_clk;

  duck_palette_sched #(
    .NUM_LAYERS(NL)
`ifdef DUCK_FLASH_EN
    , .FLASH_PIXELS(FP)
`endif
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
`ifdef DUCK_FLASH_EN
    .i_flash_trig  (i_flash_trig),
`endif
    .i_pix_req     (i_pix_req),
    .i_layer_valid (i_layer_valid),
    .i_layer_index (i_layer_index),
    .o_pal_index   (o_pal_index),
    .i_pal_red     (i_pal_red),
    .i_pal_green   (i_pal_green),
    .i_pal_blue    (i_pal_blue),
    .o_red         (o_red),
    .o_green       (o_green),
    .o_blue        (o_blue),
    .o_rgb_valid   (o_rgb_valid),
    .o_busy        (o_busy)
  );

  // Behavioural synchronous palette ROM
  logic [11:0] rom [16];
  initial begin
    rom[0]  = 12'hAEA; rom[1]  = 12'hA01; rom[2]  = 12'hFFF; rom[3]  = 12'h123;
    rom[4]  = 12'hF76; rom[5]  = 12'h5C3; rom[6]  = 12'h0F0; rom[7]  = 12'h7B2;
    rom[8]  = 12'h842; rom[9]  = 12'h9D9; rom[10] = 12'h3AF; rom[11] = 12'hB05;
    rom[12] = 12'hC6E; rom[13] = 12'h2D4; rom[14] = 12'hE18; rom[15] = 12'h6F7;
  end
  always @(posedge i_clk) {i_pal_red, i_pal_green, i_pal_blue} <= rom[o_pal_index];

  typedef struct {
    logic [NL-1:0]   valid;
    logic [4*NL-1:0] index;
    logic [3:0]      expIdx;
    int              expLat;
    logic [11:0]     expRgb;
  } vec_t;

  vec_t vecs[7];
  int   nVec = 0;
  int   nBad = 0;
  int   flashCnt = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nBad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Priority pick from the rules: first covering layer with a non-zero index wins.
  function automatic void refModel(input logic [NL-1:0] v, input logic [4*NL-1:0] idx,
                                   input int fc, output logic [3:0] expIdx, output int expLat);
    bit found = 1'b0;
    expIdx = 4'd0;
    expLat = NL + 2;
    for (int i = 0; i < NL; i++) begin
      if (!found && v[i] && (idx[4*i +: 4] != 4'd0)) begin
        found  = 1'b1;
        expIdx = (fc > 0) ? 4'd2 : idx[4*i +: 4];
        expLat = i + 3;
      end
    end
  endfunction

  task automatic applyStimulus(input logic [NL-1:0] v, input logic [4*NL-1:0] idx,
                               output int lat, output logic busyE0);
    i_layer_valid = v;
    i_layer_index = idx;
    i_pix_req     = 1'b1;
    @(posedge i_clk); #1;
    i_pix_req     = 1'b0;
    busyE0        = o_busy;
    i_layer_valid = NL'($urandom);
    i_layer_index = (4*NL)'($urandom);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge i_clk); #1;
      if (o_rgb_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic runPixel(input string name, input logic [NL-1:0] v, input logic [4*NL-1:0] idx);
    logic [3:0] eIdx;
    int         eLat;
    int         lat;
    logic       b;
    refModel(v, idx, flashCnt, eIdx, eLat);
    applyStimulus(v, idx, lat, b);
    checkOutput({name, " latency"}, lat, eLat);
    checkOutput({name, " pal_index"}, o_pal_index, eIdx);
    checkOutput({name, " rgb"}, {o_red, o_green, o_blue}, rom[eIdx]);
    if (flashCnt > 0) flashCnt--;
  endtask

`ifdef DUCK_FLASH_EN
  task automatic pulseFlash();
    i_flash_trig = 1'b1;
    @(posedge i_clk); #1;
    i_flash_trig = 1'b0;
    flashCnt = int'(FP);
  endtask
`endif

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         lat;
    int         pulses;
    logic       b;
    logic [11:0] seenRgb;
    logic [NL-1:0]   rv;
    logic [4*NL-1:0] ri;

    vecs[0] = '{4'b0001, 16'h0001, 4'd1,  3, 12'hA01};
    vecs[1] = '{4'b0100, 16'h0400, 4'd4,  5, 12'hF76};
    vecs[2] = '{4'b0000, 16'h1234, 4'd0,  6, 12'hAEA};
    vecs[3] = '{4'b1111, 16'h0000, 4'd0,  6, 12'hAEA};
    vecs[4] = '{4'b1110, 16'h9870, 4'd7,  4, 12'h7B2};
    vecs[5] = '{4'b1000, 16'hC000, 4'd12, 6, 12'hC6E};
    vecs[6] = '{4'b0011, 16'h0050, 4'd5,  4, 12'h5C3};

    #2 i_rst_n = 1'b0;
    #1;
    checkOutput("reset pal_index", o_pal_index, 0);
    checkOutput("reset rgb", {o_red, o_green, o_blue}, 0);
    checkOutput("reset rgb_valid", o_rgb_valid, 0);
    checkOutput("reset busy", o_busy, 0);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk) i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].index, lat, b);
      checkOutput($sformatf("vec%0d latency", i), lat, vecs[i].expLat);
      checkOutput($sformatf("vec%0d busy", i), b, 1);
      checkOutput($sformatf("vec%0d pal_index", i), o_pal_index, vecs[i].expIdx);
      checkOutput($sformatf("vec%0d rgb", i), {o_red, o_green, o_blue}, vecs[i].expRgb);
      @(posedge i_clk); #1;
      checkOutput($sformatf("vec%0d valid pulse", i), o_rgb_valid, 0);
      checkOutput($sformatf("vec%0d idle", i), o_busy, 0);
    end

    // Second request during SCAN must be ignored.
    i_layer_valid = 4'b1000;
    i_layer_index = 16'h3000;
    i_pix_req = 1'b1;
    @(posedge i_clk); #1;
    i_pix_req = 1'b0;
    pulses = 0;
    seenRgb = '0;
    for (int k = 1; k <= 14; k++) begin
      if (k == 2) begin
        i_layer_valid = 4'b0001;
        i_layer_index = 16'h0005;
        i_pix_req = 1'b1;
      end else begin
        i_pix_req = 1'b0;
      end
      @(posedge i_clk); #1;
      if (o_rgb_valid) begin
        pulses++;
        seenRgb = {o_red, o_green, o_blue};
      end
    end
    i_pix_req = 1'b0;
    checkOutput("scan-ignore pulses", pulses, 1);
    checkOutput("scan-ignore rgb", seenRgb, 12'h123);
    checkOutput("scan-ignore pal_index", o_pal_index, 3);

    // Reset during LOOKUP aborts the pixel.
    i_layer_valid = 4'b0001;
    i_layer_index = 16'h0001;
    i_pix_req = 1'b1;
    @(posedge i_clk); #1;
    i_pix_req = 1'b0;
    @(posedge i_clk); #1;
    i_rst_n = 1'b0;
    #1;
    checkOutput("abort pal_index", o_pal_index, 0);
    checkOutput("abort rgb", {o_red, o_green, o_blue}, 0);
    checkOutput("abort rgb_valid", o_rgb_valid, 0);
    checkOutput("abort busy", o_busy, 0);
    @(negedge i_clk) i_rst_n = 1'b1;
    flashCnt = 0;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge i_clk); #1;
      if (o_rgb_valid) pulses++;
    end
    checkOutput("abort no pulse", pulses, 0);
    runPixel("after-abort", 4'b0010, 16'h00E0);

`ifdef DUCK_FLASH_EN
    pulseFlash();
    runPixel("flash1", 4'b0001, 16'h0001);
    runPixel("flash2", 4'b0001, 16'h0001);
    runPixel("flash3", 4'b0001, 16'h0001);
    pulseFlash();
    runPixel("flash-bg", 4'b0000, 16'h0001);
`endif

    for (int n = 0; n < 60; n++) begin
      rv = NL'($urandom);
      for (int j = 0; j < NL; j++) begin
        ri[4*j +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
      end
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge i_clk); #1;
        end
      end
`ifdef DUCK_FLASH_EN
      if ($urandom_range(0, 7) == 0) pulseFlash();
`endif
      runPixel($sformatf("rand%0d", n), rv, ri);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end

endmodule
